// File: rtl/matrix_gather_pkg.sv
// Shared types and helpers for the matrix gather block: bank select and counter sizing.
package matrix_gather_pkg;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  // A one-beat matrix still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/matrix_gather_bank.sv
// One storage bank: beat-indexed write of PAR elements, whole-matrix flat read.
module matrix_bank #(
  parameter int WIDTH = 8,
  parameter int ELEMS = 4,
  parameter int PAR   = 2,
  parameter int CW    = 1
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_beat,
  input  logic [PAR-1:0][WIDTH-1:0]  wr_data,
  output logic [ELEMS-1:0][WIDTH-1:0] rd_data
);

  localparam int BEATS = ELEMS / PAR;

  logic [ELEMS-1:0][WIDTH-1:0] mem;

  // Constant indices per beat keep the write decode free of wide index arithmetic.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar k = 0; k < PAR; k++) begin : g_elem
      always_ff @(posedge clk) begin
        if (wr_en && (wr_beat == CW'(b))) begin
          mem[b*PAR+k] <= wr_data[k];
        end
      end
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/matrix_gather.sv
// Ping-pong gather of PAR-element beats into a full DIM1 x DIM0 row-major matrix.
module matrix_gather
  import matrix_gather_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIM1  = 2,
  parameter int DIM0  = 2,
  parameter int PAR   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PAR-1:0][WIDTH-1:0]          in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DIM1*DIM0-1:0][WIDTH-1:0]    out_data,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int ELEMS = DIM1 * DIM0;
  localparam int BEATS = ELEMS / PAR;
  localparam int CW    = cnt_width(BEATS);

  if ((ELEMS % PAR) != 0) begin : g_bad_par
    $fatal(1, "matrix_gather: DIM1*DIM0 must be divisible by PAR");
  end

  bank_e         wr_bank, rd_bank, wr_nxt, rd_nxt;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic [1:0]    full, full_nxt;
  logic          in_hs, out_hs, last_beat;
  logic [ELEMS-1:0][WIDTH-1:0] rd0, rd1;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  // in_hs and out_hs can never target the same bank: one needs it empty, the other full.
  always_comb begin
    full_nxt = full;
    wr_nxt   = wr_bank;
    rd_nxt   = rd_bank;
    cnt_nxt  = beat_cnt;
    if (out_hs) begin
      full_nxt[rd_bank] = 1'b0;
      rd_nxt            = bank_e'(~rd_bank);
    end
    if (in_hs) begin
      if (last_beat) begin
        cnt_nxt           = '0;
        full_nxt[wr_bank] = 1'b1;
        wr_nxt            = bank_e'(~wr_bank);
      end else begin
        cnt_nxt = beat_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank  <= BANK0;
      rd_bank  <= BANK0;
      beat_cnt <= '0;
      full     <= '0;
    end else begin
      wr_bank  <= wr_nxt;
      rd_bank  <= rd_nxt;
      beat_cnt <= cnt_nxt;
      full     <= full_nxt;
    end
  end

  matrix_bank #(.WIDTH(WIDTH), .ELEMS(ELEMS), .PAR(PAR), .CW(CW)) u_bank0 (
    .clk     (clk),
    .wr_en   (in_hs && (wr_bank == BANK0)),
    .wr_beat (beat_cnt),
    .wr_data (in_data),
    .rd_data (rd0)
  );

  matrix_bank #(.WIDTH(WIDTH), .ELEMS(ELEMS), .PAR(PAR), .CW(CW)) u_bank1 (
    .clk     (clk),
    .wr_en   (in_hs && (wr_bank == BANK1)),
    .wr_beat (beat_cnt),
    .wr_data (in_data),
    .rd_data (rd1)
  );

  assign out_data = (rd_bank == BANK1) ? rd1 : rd0;

endmodule

// File: tb/tb_matrix_gather.sv
// Directed and random checks of matrix_gather against a queue-based matrix model.
module tb_matrix_gather;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][7:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][7:0]  out_data;
  logic             out_valid;
  logic             out_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;

  // Model: completed matrices awaiting output, plus the matrix being assembled.
  logic [31:0] q[$];
  logic [7:0]  part[4];
  int          nbeat = 0;

  always #5 clk = ~clk;

  matrix_gather #(.WIDTH(8), .DIM1(2), .DIM0(2), .PAR(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a falling edge: check, drive, advance one cycle, update model.
  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ordy);
    logic ihs, ohs;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    in_valid   = iv;
    in_data[0] = a;
    in_data[1] = b;
    out_ready  = ordy;
    ihs = iv && (q.size() < 2);
    ohs = ordy && (q.size() > 0);
    @(posedge clk);
    if (ohs) begin
      void'(q.pop_front());
      n_out++;
    end
    if (ihs) begin
      part[nbeat*2]   = a;
      part[nbeat*2+1] = b;
      nbeat++;
      if (nbeat == 2) begin
        q.push_back({part[3], part[2], part[1], part[0]});
        nbeat = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    nbeat = 0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Basic fill with one-cycle latency
    step(1'b1, 8'd1, 8'd2, 1'b1);
    chk("fill mid out_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'd3, 8'd4, 1'b1);
    chk("fill out_valid", {31'd0, out_valid}, 32'd1);
    chk("fill out_data", out_data, 32'h04030201);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("fill drained", {31'd0, out_valid}, 32'd0);

    // Three matrices into a stalled sink
    step(1'b1, 8'hA0, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 8'hA3, 1'b0);
    step(1'b1, 8'hB0, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 8'hB3, 1'b0);
    chk("stall in_ready low", {31'd0, in_ready}, 32'd0);
    step(1'b1, 8'hC0, 8'hC1, 1'b0);
    chk("stall C0 refused", {31'd0, in_ready}, 32'd0);

    // Hold stability with out_ready low
    for (int i = 0; i < 5; i++) begin
      chk("hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold out_data", out_data, 32'hA3A2A1A0);
      step(1'b1, 8'hC0, 8'hC1, 1'b0);
    end
    chk("order A", out_data, 32'hA3A2A1A0);
    step(1'b1, 8'hC0, 8'hC1, 1'b1);
    chk("in_ready after pop", {31'd0, in_ready}, 32'd1);
    chk("order B", out_data, 32'hB3B2B1B0);
    step(1'b1, 8'hC0, 8'hC1, 1'b1);
    step(1'b1, 8'hC2, 8'hC3, 1'b0);
    chk("C accepted", out_data, 32'hC3C2C1C0);
    step(1'b0, 8'd0, 8'd0, 1'b1);

    // Final beat into bank 1 while bank 0 drains
    do_reset();
    step(1'b1, 8'h11, 8'h12, 1'b0);
    step(1'b1, 8'h13, 8'h14, 1'b0);
    step(1'b1, 8'h21, 8'h22, 1'b0);
    step(1'b1, 8'h23, 8'h24, 1'b1);
    chk("simul out_valid", {31'd0, out_valid}, 32'd1);
    chk("simul out_data", out_data, 32'h24232221);
    chk("simul in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b1);

    // Reset after one beat discards it
    step(1'b1, 8'h55, 8'h66, 1'b0);
    do_reset();
    step(1'b1, 8'd9, 8'd8, 1'b1);
    step(1'b1, 8'd7, 8'd6, 1'b1);
    chk("post-reset data", out_data, 32'h06070809);
    step(1'b0, 8'd0, 8'd0, 1'b1);

    // Random traffic
    n_out = 0;
    cyc = 0;
    while (n_out < 1000 && cyc < 40000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("random matrices out", {31'd0, n_out >= 1000}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_gather.md
MATRIX_GATHER -- requirements
Module: matrix_gather

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning element bit width.
REQ-002 The block SHALL have parameter DIM1, default 2, meaning matrix rows (N).
REQ-003 The block SHALL have parameter DIM0, default 2, meaning matrix columns (M).
REQ-004 The block SHALL have parameter PAR, default 2, meaning elements per input beat.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset: synchronous, active-low.
REQ-007 The block SHALL have port in_data, input, array [PAR-1:0] of WIDTH bits, meaning one beat of elements in row-major order.
REQ-008 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit, forming the upstream handshake.
REQ-009 The block SHALL have port out_data, output, array [DIM1*DIM0-1:0] of WIDTH bits, meaning the full matrix in row-wise ordering, the same layout consumed by the matmul x/y inputs.
REQ-010 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit, forming the downstream handshake.

Function
REQ-011 A handshake SHALL occur on a side when valid and ready are both high at a rising clk edge.
REQ-012 BEATS SHALL be DIM1*DIM0/PAR; elaboration SHALL $fatal if DIM1*DIM0 is not divisible by PAR.
REQ-013 Storage SHALL be two banks (ping-pong), each holding DIM1*DIM0 elements.
REQ-014 State SHALL be: wr_bank (1b), rd_bank (1b), beat_cnt (clog2(BEATS) bits), full[1:0].
REQ-015 Beat b (0-based) of a matrix SHALL be written to elements [b*PAR +: PAR] of bank wr_bank; in_data[k] SHALL map to element b*PAR+k.
REQ-016 in_ready SHALL equal !full[wr_bank] and SHALL be driven from registers only, with no combinational path from out_ready or in_valid.
REQ-017 On an input handshake with beat_cnt < BEATS-1, beat_cnt SHALL increment.
REQ-018 On an input handshake with beat_cnt == BEATS-1, beat_cnt SHALL wrap to 0, full[wr_bank] SHALL set, and wr_bank SHALL toggle.
REQ-019 out_valid SHALL equal full[rd_bank].
REQ-020 out_data SHALL equal the contents of bank rd_bank and SHALL be held stable while out_valid is high and out_ready is low.
REQ-021 On an output handshake, full[rd_bank] SHALL clear and rd_bank SHALL toggle.
REQ-022 Latency SHALL be one cycle: out_valid rises in the cycle after the last-beat input handshake.
REQ-023 A final-beat write to one bank and an output handshake on the other bank in the same cycle SHALL both take effect.
REQ-024 With both banks full, in_ready SHALL be 0 until an output handshake occurs; in_ready SHALL rise in the following cycle.
REQ-025 Sustained throughput SHALL be one beat per cycle whenever the downstream accepts each matrix within BEATS cycles of its out_valid.
REQ-026 When BEATS == 1, every input handshake SHALL complete a matrix.

Reset
REQ-027 While rst is low at a clk edge, wr_bank, rd_bank, beat_cnt and full SHALL be set to 0, so that in_ready=1 and out_valid=0 after the edge.
REQ-028 Bank data SHALL NOT be reset.
REQ-029 A reset mid-matrix SHALL discard partial and full banks; the next accepted beat SHALL be beat 0 of bank 0.

Structure
REQ-030 The function SHALL be a single module; no shared package is required, and BEATS and the counter width SHALL be local constants.
REQ-031 An optional sub-module matrix_bank SHALL be allowed: one bank, with a write port (beat index plus beat data) and a flat read port, instantiated twice.

Verification (WIDTH=8, DIM1=2, DIM0=2, PAR=2, BEATS=2)
REQ-032 Basic fill: beats {1,2} then {3,4} with out_ready=1 -> out_valid one cycle after the 2nd handshake; out_data[0..3]={1,2,3,4}.
REQ-033 Back-to-back with stalled sink: 3 matrices streamed, out_ready=0 -> 4 beats accepted, then in_ready=0; after 2 output handshakes the order is matrix A then B, and matrix C is then accepted.
REQ-034 Simultaneous events: final beat of bank 1 in the same cycle as the output handshake of bank 0 -> both take effect; next cycle out_valid=1 with the bank 1 data.
REQ-035 Hold stability: out_ready held low for 5 cycles -> out_data and out_valid unchanged throughout.
REQ-036 Reset mid-operation: rst low after 1 beat -> in_ready=1 and out_valid=0; the next beats {9,8},{7,6} produce {9,8,7,6}.
REQ-037 Random valid/ready traffic against a reference queue -> no loss, no duplication, no reordering over 1000 matrices.
